if_fetch_unit: RTL and testbench

- Instruction-fetch stage of the pipelined CPU. Owns the PC register and drives it to the next-PC block; consumes that block's result (npc_in) and the EX/MEM-stage npc_op.
- Issues instruction-memory requests over a req/ready handshake and fills the IF/ID pipeline register.
- Honours stalls from the hazard unit. Squashes wrong-path fetches on any redirect (branch, jump, jalr).

---
 rtl/if_fetch_unit_pkg.sv | 28 ++
 rtl/if_skid_buf.sv | 44 ++++
 rtl/if_fetch_unit.sv | 134 +++++++++++++
 tb/tb_if_fetch_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared control encodings for the instruction-fetch stage: next-PC
// operation codes, the canonical NOP word and the fetch FSM states.
package if_fetch_unit_pkg;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // Any code other than sequential fetch (including unassigned codes)
  // moves the PC off the predicted path and must squash in-flight work.
  function automatic logic npc_is_redirect(input logic [2:0] op);
    case (op)
      NPC_PLUS4:                      return 1'b0;
      NPC_BRANCH, NPC_JUMP, NPC_JALR: return 1'b1;
      default:                        return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register for a fetched {pc, instr} pair that arrived
// while IF/ID was stalled. Clear takes priority over load.
module if_skid_buf
  import if_fetch_unit_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          clear_i,
  input  logic [AW-1:0] pc_i,
  input  logic [31:0]   instr_i,
  output logic          valid_o,
  output logic [AW-1:0] pc_o,
  output logic [31:0]   instr_o
);

  logic          valid_q;
  logic [AW-1:0] pc_q;
  logic [31:0]   instr_q;

  // Occupancy flag: reset and clear empty the entry, load fills it
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
    end
  end

  // Payload only needs to be correct while valid_q is set
  always_ff @(posedge clk) begin
    if (load_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one instruction-memory
// request at a time over req/ready, fills IF/ID, parks a response in a
// skid entry while ID is stalled, and drains a stale request after a
// redirect so a wrong-path response never reaches IF/ID.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          AW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    npc_op,
  input  logic [AW-1:0] npc_in,
  output logic [AW-1:0] pc_out,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic [31:0]   imem_rdata,
  input  logic          stall,
  output logic          ifid_valid,
  output logic [AW-1:0] ifid_pc,
  output logic [31:0]   ifid_instr,
  output logic          flush
);

  fetch_state_e  state_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] req_addr_q;
  logic          ifid_valid_q;
  logic [AW-1:0] ifid_pc_q;
  logic [31:0]   ifid_instr_q;

  logic          redirect;
  logic          accept;
  logic          skid_load;
  logic          skid_clear;
  logic          skid_valid;
  logic [AW-1:0] skid_pc;
  logic [31:0]   skid_instr;
  logic [AW-1:0] pc_plus4;

  assign redirect = npc_is_redirect(npc_op);
  assign flush    = redirect;

  // A response can enter IF/ID when ID is advancing or IF/ID is empty
  assign accept   = imem_ready && (!stall || !ifid_valid_q);
  assign pc_plus4 = pc_q + AW'(4);

  // Response arrived but IF/ID is held: park it instead of dropping it
  assign skid_load  = (state_q == ST_FETCH) && !redirect && imem_ready && !accept;
  assign skid_clear = redirect || ((state_q == ST_HOLD) && !stall);

  if_skid_buf #(
    .AW (AW)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .pc_i    (req_addr_q),
    .instr_i (imem_rdata),
    .valid_o (skid_valid),
    .pc_o    (skid_pc),
    .instr_o (skid_instr)
  );

  // Fetch FSM with PC, request address and IF/ID register; redirect outranks
  // everything but reset, and a request left unanswered by a redirect is
  // drained so its address stays stable until memory responds
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
    end else if (redirect) begin
      pc_q         <= npc_in;
      ifid_valid_q <= 1'b0;
      if ((state_q != ST_HOLD) && !imem_ready) begin
        state_q <= ST_DRAIN;
      end else begin
        state_q    <= ST_FETCH;
        req_addr_q <= npc_in;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (accept) begin
            ifid_valid_q <= 1'b1;
            ifid_pc_q    <= req_addr_q;
            ifid_instr_q <= imem_rdata;
            pc_q         <= npc_in;
            req_addr_q   <= npc_in;
          end else if (imem_ready) begin
            pc_q    <= pc_plus4;
            state_q <= ST_HOLD;
          end else if (!stall) begin
            // ID consumed the held instruction and nothing replaces it
            ifid_valid_q <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            ifid_valid_q <= skid_valid;
            ifid_pc_q    <= skid_pc;
            ifid_instr_q <= skid_instr;
            req_addr_q   <= pc_q;
            state_q      <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (imem_ready) begin
            req_addr_q <= pc_q;
            state_q    <= ST_FETCH;
          end
        end
        default: begin
          state_q <= ST_FETCH;
        end
      endcase
    end
  end

  assign pc_out     = pc_q;
  assign imem_addr  = req_addr_q;
  assign imem_req   = (state_q != ST_HOLD);
  assign ifid_valid = ifid_valid_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_instr = ifid_instr_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model
// (current PC, address owed by memory, a queue for the parked response).
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  npc_op;
  logic [31:0] npc_in;
  logic [31:0] pc_out;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        flush;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .AW       (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .npc_op     (npc_op),
    .npc_in     (npc_in),
    .pc_out     (pc_out),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .ifid_valid (ifid_valid),
    .ifid_pc    (ifid_pc),
    .ifid_instr (ifid_instr),
    .flush      (flush)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetched_t;

  logic [31:0] m_pc;     // architectural fetch PC
  logic [31:0] m_addr;   // address the memory is being asked for
  logic        m_drain;  // a wrong-path request is still owed a response
  logic        m_v;
  logic [31:0] m_ipc;
  logic [31:0] m_ins;
  fetched_t    m_parked[$];

  task automatic model_reset();
    m_pc    = 32'h0;
    m_addr  = 32'h0;
    m_drain = 1'b0;
    m_v     = 1'b0;
    m_ipc   = 32'h0;
    m_ins   = 32'h0000_0013;
    m_parked.delete();
  endtask

  task automatic model_step(input logic rs, input logic s, input logic r,
                            input logic [31:0] rd, input logic [2:0] op,
                            input logic [31:0] npc);
    fetched_t f;
    if (rs) begin
      model_reset();
    end else if (op != 3'b000) begin
      // wrong path: squash everything; an unanswered request must be drained
      if (m_parked.size() == 0 && !r) m_drain = 1'b1;
      else begin
        m_drain = 1'b0;
        m_addr  = npc;
      end
      m_pc = npc;
      m_v  = 1'b0;
      m_parked.delete();
    end else if (m_parked.size() != 0) begin
      if (!s) begin
        f      = m_parked.pop_front();
        m_v    = 1'b1;
        m_ipc  = f.pc;
        m_ins  = f.instr;
        m_addr = m_pc;
      end
    end else if (m_drain) begin
      if (r) begin
        m_drain = 1'b0;
        m_addr  = m_pc;
      end
    end else if (r && (!s || !m_v)) begin
      m_v    = 1'b1;
      m_ipc  = m_addr;
      m_ins  = rd;
      m_pc   = npc;
      m_addr = npc;
    end else if (r) begin
      f.pc    = m_addr;
      f.instr = rd;
      m_parked.push_back(f);
      m_pc = m_pc + 32'd4;
    end else if (!s) begin
      m_v = 1'b0;
    end
  endtask

  // Drive one cycle of inputs; a sequential npc_op behaves like the real
  // next-PC block and supplies pc+4.
  task automatic set_inputs(input logic rs, input logic s, input logic r,
                            input logic [31:0] rd, input logic [2:0] op,
                            input logic [31:0] npc);
    rst        = rs;
    stall      = s;
    imem_ready = r;
    imem_rdata = rd;
    npc_op     = op;
    npc_in     = (op == NPC_PLUS4) ? (m_pc + 32'd4) : npc;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(rst, stall, imem_ready, imem_rdata, npc_op, npc_in);
    #1;
  endtask

  task automatic reset_dut();
    set_inputs(1'b1, 1'b0, 1'b0, 32'h0, NPC_PLUS4, 32'h0);
    tick();
  endtask

  // Memory that returns its own address as the instruction word
  task automatic fetch_seq(input int n);
    for (int i = 0; i < n; i++) begin
      set_inputs(1'b0, 1'b0, 1'b1, imem_addr, NPC_PLUS4, 32'h0);
      tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_inputs(1'b1, 1'b1, 1'b1, $urandom, NPC_JALR, $urandom);
    tick();
    set_inputs(1'b1, 1'b0, 1'b1, $urandom, NPC_PLUS4, 32'h0);
    tick();
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc_out, 32'h0); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, 32'h0); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL reset_req got=%b exp=1", imem_req); end
    checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ifid_valid); end
    checks++; if (ifid_pc !== 32'h0) begin failures++; $display("FAIL reset_ifid_pc got=%h exp=%h", ifid_pc, 32'h0); end
    checks++; if (ifid_instr !== 32'h0000_0013) begin failures++; $display("FAIL reset_nop got=%h exp=%h", ifid_instr, 32'h13); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", flush); end
  endtask

  task automatic test_sequential();
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      set_inputs(1'b0, 1'b0, 1'b1, imem_addr, NPC_PLUS4, 32'h0);
      tick();
      checks++; if (ifid_valid !== 1'b1) begin failures++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, ifid_valid); end
      checks++; if (ifid_pc !== 32'(4 * i)) begin failures++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, ifid_pc, 32'(4 * i)); end
      checks++; if (ifid_instr !== 32'(4 * i)) begin failures++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, ifid_instr, 32'(4 * i)); end
      checks++; if (pc_out !== 32'(4 * i + 4)) begin failures++; $display("FAIL seq_pcout[%0d] got=%h exp=%h", i, pc_out, 32'(4 * i + 4)); end
    end
  endtask

  task automatic test_stall_hold();
    reset_dut();
    fetch_seq(4);
    checks++; if (imem_addr !== 32'h10) begin failures++; $display("FAIL hold_pre_addr got=%h exp=%h", imem_addr, 32'h10); end
    for (int k = 0; k < 3; k++) begin
      set_inputs(1'b0, 1'b1, 1'b1, imem_addr, NPC_PLUS4, 32'h0);
      tick();
      checks++; if (ifid_pc !== 32'h0C) begin failures++; $display("FAIL hold_ifid_pc[%0d] got=%h exp=%h", k, ifid_pc, 32'h0C); end
      checks++; if (ifid_valid !== 1'b1) begin failures++; $display("FAIL hold_valid[%0d] got=%b exp=1", k, ifid_valid); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL hold_req[%0d] got=%b exp=0", k, imem_req); end
    end
    checks++; if (pc_out !== 32'h14) begin failures++; $display("FAIL hold_pc got=%h exp=%h", pc_out, 32'h14); end
    set_inputs(1'b0, 1'b0, 1'b1, 32'hFEED_0000, NPC_PLUS4, 32'h0);
    tick();
    checks++; if (ifid_pc !== 32'h10) begin failures++; $display("FAIL release_pc got=%h exp=%h", ifid_pc, 32'h10); end
    checks++; if (ifid_instr !== 32'h10) begin failures++; $display("FAIL release_instr got=%h exp=%h", ifid_instr, 32'h10); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL release_req got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h14) begin failures++; $display("FAIL release_addr got=%h exp=%h", imem_addr, 32'h14); end
    fetch_seq(1);
    checks++; if (ifid_pc !== 32'h14) begin failures++; $display("FAIL after_release_pc got=%h exp=%h", ifid_pc, 32'h14); end
  endtask

  task automatic test_branch_drain();
    reset_dut();
    fetch_seq(8);
    set_inputs(1'b0, 1'b0, 1'b0, 32'h0, NPC_BRANCH, 32'h100);
    #1;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL br_flush got=%b exp=1", flush); end
    tick();
    checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL br_valid got=%b exp=0", ifid_valid); end
    checks++; if (pc_out !== 32'h100) begin failures++; $display("FAIL br_pc got=%h exp=%h", pc_out, 32'h100); end
    for (int k = 0; k < 2; k++) begin
      set_inputs(1'b0, 1'b0, 1'b0, 32'h0, NPC_PLUS4, 32'h0);
      tick();
      checks++; if (imem_addr !== 32'h20 || imem_req !== 1'b1) begin failures++; $display("FAIL drain_addr[%0d] got=%h/%b exp=%h/1", k, imem_addr, imem_req, 32'h20); end
    end
    set_inputs(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, NPC_PLUS4, 32'h0);
    tick();
    checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL drain_discard got=%b exp=0", ifid_valid); end
    checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL drain_next_addr got=%h exp=%h", imem_addr, 32'h100); end
    fetch_seq(1);
    checks++; if (ifid_pc !== 32'h100 || ifid_instr !== 32'h100) begin failures++; $display("FAIL br_target got=%h/%h exp=%h", ifid_pc, ifid_instr, 32'h100); end
  endtask

  task automatic test_jalr_stall();
    set_inputs(1'b0, 1'b1, 1'b1, 32'h0BAD_0BAD, NPC_JALR, 32'h204);
    #1;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL jalr_flush got=%b exp=1", flush); end
    tick();
    checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL jalr_valid got=%b exp=0", ifid_valid); end
    checks++; if (imem_addr !== 32'h204 || imem_req !== 1'b1) begin failures++; $display("FAIL jalr_addr got=%h/%b exp=%h/1", imem_addr, imem_req, 32'h204); end
    fetch_seq(1);
    checks++; if (ifid_pc !== 32'h204 || ifid_valid !== 1'b1) begin failures++; $display("FAIL jalr_target got=%h/%b exp=%h/1", ifid_pc, ifid_valid, 32'h204); end
  endtask

  task automatic test_double_redirect();
    set_inputs(1'b0, 1'b0, 1'b0, 32'h0, NPC_BRANCH, 32'h300);
    tick();
    checks++; if (imem_addr !== 32'h208) begin failures++; $display("FAIL dbl_stale1 got=%h exp=%h", imem_addr, 32'h208); end
    set_inputs(1'b0, 1'b0, 1'b0, 32'h0, NPC_JUMP, 32'h400);
    tick();
    checks++; if (imem_addr !== 32'h208) begin failures++; $display("FAIL dbl_stale2 got=%h exp=%h", imem_addr, 32'h208); end
    checks++; if (pc_out !== 32'h400) begin failures++; $display("FAIL dbl_pc got=%h exp=%h", pc_out, 32'h400); end
    set_inputs(1'b0, 1'b0, 1'b1, 32'h1234_5678, NPC_PLUS4, 32'h0);
    tick();
    checks++; if (imem_addr !== 32'h400 || ifid_valid !== 1'b0) begin failures++; $display("FAIL dbl_next got=%h/%b exp=%h/0", imem_addr, ifid_valid, 32'h400); end
    fetch_seq(1);
    checks++; if (ifid_pc !== 32'h400) begin failures++; $display("FAIL dbl_target got=%h exp=%h", ifid_pc, 32'h400); end
  endtask

  task automatic test_wrap_and_reset();
    set_inputs(1'b0, 1'b0, 1'b1, 32'h0, NPC_JUMP, 32'hFFFF_FFF8);
    tick();
    fetch_seq(1);
    checks++; if (pc_out !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pre got=%h exp=%h", pc_out, 32'hFFFF_FFFC); end
    // stalled response at the top address: internal pc+4 must wrap
    set_inputs(1'b0, 1'b1, 1'b1, imem_addr, NPC_PLUS4, 32'h0);
    tick();
    checks++; if (pc_out !== 32'h0 || imem_req !== 1'b0) begin failures++; $display("FAIL wrap_hold got=%h/%b exp=0/0", pc_out, imem_req); end
    set_inputs(1'b0, 1'b0, 1'b0, 32'h0, NPC_PLUS4, 32'h0);
    tick();
    checks++; if (ifid_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_release got=%h/%h exp=%h/0", ifid_pc, imem_addr, 32'hFFFF_FFFC); end
    // accepted response at the top address
    set_inputs(1'b0, 1'b0, 1'b1, 32'h0, NPC_JUMP, 32'hFFFF_FFFC);
    tick();
    fetch_seq(1);
    checks++; if (pc_out !== 32'h0 || ifid_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_accept got=%h/%h exp=0/%h", pc_out, ifid_pc, 32'hFFFF_FFFC); end
    // reset while draining
    set_inputs(1'b0, 1'b0, 1'b0, 32'h0, NPC_BRANCH, 32'h500);
    tick();
    set_inputs(1'b1, 1'b1, 1'b1, 32'hAAAA_5555, NPC_PLUS4, 32'h0);
    tick();
    checks++; if (pc_out !== 32'h0 || imem_addr !== 32'h0 || imem_req !== 1'b1 || ifid_valid !== 1'b0) begin failures++; $display("FAIL rst_drain got pc=%h addr=%h req=%b v=%b exp 0/0/1/0", pc_out, imem_addr, imem_req, ifid_valid); end
    fetch_seq(1);
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0) begin failures++; $display("FAIL rst_drain_fetch got=%b/%h exp=1/0", ifid_valid, ifid_pc); end
  endtask

  task automatic test_random();
    logic        rs, s, r;
    logic [2:0]  op;
    logic [2:0]  redir_ops [4];
    logic [31:0] npc;
    redir_ops[0] = NPC_BRANCH;
    redir_ops[1] = NPC_JUMP;
    redir_ops[2] = NPC_JALR;
    redir_ops[3] = 3'b011;
    reset_dut();
    for (int n = 0; n < 3000; n++) begin
      rs  = ($urandom_range(0, 499) == 0);
      s   = ($urandom_range(0, 99) < 30);
      r   = ($urandom_range(0, 99) < 60);
      op  = ($urandom_range(0, 99) < 10) ? redir_ops[$urandom_range(0, 3)] : NPC_PLUS4;
      npc = $urandom;
      set_inputs(rs, s, r, $urandom, op, npc);
      #1;
      checks++; if (flush !== (op != NPC_PLUS4)) begin failures++; $display("FAIL rnd_flush[%0d] got=%b exp=%b", n, flush, op != NPC_PLUS4); end
      checks++; if (imem_req !== (m_parked.size() == 0)) begin failures++; $display("FAIL rnd_req[%0d] got=%b exp=%b", n, imem_req, m_parked.size() == 0); end
      if (m_parked.size() == 0) begin
        checks++; if (imem_addr !== m_addr) begin failures++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", n, imem_addr, m_addr); end
      end
      tick();
      checks++; if (pc_out !== m_pc) begin failures++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", n, pc_out, m_pc); end
      checks++; if (ifid_valid !== m_v) begin failures++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", n, ifid_valid, m_v); end
      checks++; if (ifid_pc !== m_ipc || ifid_instr !== m_ins) begin failures++; $display("FAIL rnd_ifid[%0d] got=%h/%h exp=%h/%h", n, ifid_pc, ifid_instr, m_ipc, m_ins); end
    end
  endtask

  initial begin
    model_reset();
    set_inputs(1'b1, 1'b0, 1'b0, 32'h0, NPC_PLUS4, 32'h0);
    test_reset();
    test_sequential();
    test_stall_hold();
    test_branch_drain();
    test_jalr_stall();
    test_double_redirect();
    test_wrap_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
